// File: rtl/multicycle_chunk_adder.sv
// multicycle_chunk_adder: sequential adder that consumes CHUNK bits per clock,
// LSB chunk first, with the carry held in a register between chunks.
// Start/done handshake; sum and carry_out update only when an add completes.
// Optional signed overflow flag is built when ADDER_SIGNED_OVF_EN is defined;
// otherwise the overflow port is tied low.
module multicycle_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int NUM_CHUNKS = WIDTH / CHUNK;
  localparam int IDXW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t           state;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] partial;
  logic             carry_reg;

  logic [31:0]      base;
  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic [CHUNK:0]   chunk_res;
  logic [WIDTH-1:0] next_partial;
  logic             last_chunk;

  assign base       = 32'(idx) * 32'(CHUNK);
  assign last_chunk = (idx == LAST_IDX);

  // One chunk of the add: current slice of both operands plus the held carry,
  // merged into the partial sum so the completion edge can load it directly.
  always_comb begin
    chunk_a      = op_a[base +: CHUNK];
    chunk_b      = op_b[base +: CHUNK];
    chunk_res    = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry_reg};
    next_partial = partial;
    next_partial[base +: CHUNK] = chunk_res[CHUNK-1:0];
  end

  // Control FSM with registered busy/done; operands are latched on accept so
  // input changes during the add are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      idx       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      carry_reg <= 1'b0;
      partial   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_a      <= a;
            op_b      <= b;
            carry_reg <= carry_in;
            idx       <= '0;
            partial   <= '0;
            busy      <= 1'b1;
            state     <= ADD;
          end
        end
        ADD: begin
          partial   <= next_partial;
          carry_reg <= chunk_res[CHUNK];
          if (last_chunk) begin
            sum       <= next_partial;
            carry_out <= chunk_res[CHUNK];
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef ADDER_SIGNED_OVF_EN
  // Signed overflow from the latched operand signs and the final sum sign,
  // captured on the same edge as sum so the two always describe one result.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (state == ADD && last_chunk) begin
      overflow <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                  (next_partial[WIDTH-1] != op_a[WIDTH-1]);
    end
  end
`else
  assign overflow = 1'b0;
`endif

endmodule
